fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 18-bit CPU, directly upstream of the instruction register. It owns the program counter, fetches one instruction per request from instruction memory over a req/ack handshake, and presents each instruction to the instruction register with a one-cycle `ack_o` strobe. It supports stalling and PC loads (jumps and branches), and it discards any in-flight fetch that a load makes stale.

## Interface
Parameters:
- `ADDR_W`, default 12: PC and memory address width.
- `INST_W`, default 18: instruction width.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall_i` in 1: downstream not ready; hold the delivered instruction.
- `pc_load_i` in 1: load the PC from `pc_target_i` this cycle.
- `pc_target_i` in `ADDR_W`: jump/branch target.
- `mem_req_o` out 1: fetch request to instruction memory.
- `mem_addr_o` out `ADDR_W`: fetch address; stable while `mem_req_o` is high.
- `mem_ack_i` in 1: memory data valid, single-cycle pulse.
- `mem_data_i` in `INST_W`: fetched instruction.
- `inst_o` out `INST_W`: instruction to the instruction register (its `inst_i`).
- `ack_o` out 1: one-cycle load strobe (drives the instruction register's `ack_i`).
- `pc_o` out `ADDR_W`: address of the instruction currently in `inst_o`.

## Operation
- State machine `fetch_state_t`: FETCH, ISSUE, DRAIN.
- Registers:
  - `pc`: next address to fetch.
  - `fetch_addr`: drives `mem_addr_o`; loaded from `pc` on every entry to FETCH.
  - `inst_o`, `pc_o`.
- FETCH:
  - `mem_req_o`=1.
  - On `mem_ack_i`, when `pc_load_i`=0:
    - `inst_o`<=`mem_data_i`.
    - `pc_o`<=`fetch_addr`.
    - `pc`<=`fetch_addr`+1, wrapping modulo 2^`ADDR_W` (0xFFF+1 = 0x000).
    - Next state ISSUE.
- ISSUE:
  - `mem_req_o`=0.
  - `ack_o`=1 combinationally when `stall_i`=0, then next state FETCH.
  - If `stall_i`=1: stay in ISSUE, `ack_o`=0, `inst_o` held.
- `pc_load_i` has priority over all other events:
  - It always does `pc`<=`pc_target_i`.
  - FETCH with `mem_ack_i` in the same cycle: data discarded, no ISSUE; next state FETCH at the target.
  - FETCH without `mem_ack_i`: the request is outstanding, so the address must not change. Next state DRAIN.
  - ISSUE: the pending instruction is squashed. `ack_o` is forced to 0 even if `stall_i`=0. Next state FETCH.
  - DRAIN: only `pc` is updated; the last load wins.
- DRAIN:
  - `mem_req_o`=1 with the old `fetch_addr`.
  - On `mem_ack_i`, data is discarded; next state FETCH at `pc`.
- `mem_req_o` never drops before its ack, except on reset.
- `ack_o` is never asserted twice for the same fetched word.

## Timing
- Reset values:
  - state FETCH.
  - `pc` and `fetch_addr` = `RESET_PC`.
  - `inst_o`=0, `pc_o`=0, `ack_o`=0.
  - `mem_req_o`=0 while `rst` is high.
- Reset mid-operation abandons any outstanding request.
  - The memory must drop its ack when `mem_req_o` falls.
  - An ack seen in the first cycle after reset belongs to the new request.
- Memory may ack in the same cycle `mem_req_o` rises (zero-wait) or any later cycle.
- Latency with zero-wait memory and no stall:
  - Req in cycle N, `inst_o` valid and `ack_o`=1 in cycle N+1.
  - Throughput is 1 instruction per 2 cycles.
- Each memory wait cycle adds 1 cycle of latency.
- Load during a wait costs: the remaining wait, plus 1 DRAIN ack cycle, plus a new fetch.
- `ack_o` is combinational from state and `stall_i`.
- `inst_o` and `pc_o` are registered and change only on the FETCH to ISSUE transition.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_W` and `INST_W` defaults.
  - `fetch_state_t` enum.
  - `inst_t` typedef (`logic [17:0]`).
  - `addr_t` typedef (`logic [11:0]`).
- Single module, no sub-module; the PC incrementer and state machine are inline.

## Test plan
- Reset, zero-wait memory returning data = address XOR 0x15555, no stall:
  - Fetch addresses 0,1,2,...
  - `ack_o` every second cycle.
  - `inst_o`/`pc_o` pairs are (0x15555,0), (0x15554,1), ...
- 3-cycle memory latency with `stall_i` high for 4 cycles in ISSUE:
  - `ack_o` is low during the stall.
  - `inst_o` is held.
  - Exactly one `ack_o` follows stall release.
- `pc_load_i` with target 0x0A0 while FETCH is waiting at address 5:
  - `mem_addr_o` stays 5 until ack; that data is discarded with no `ack_o`.
  - The next request is at 0x0A0, delivered with `pc_o`=0x0A0.
- `pc_load_i` in ISSUE with `stall_i`=0:
  - `ack_o` stays 0.
  - The next fetch is at the target.
- PC wrap: `RESET_PC`=0xFFF.
  - First `pc_o`=0xFFF, next fetch address 0x000.
- `rst` asserted during an outstanding 5-cycle fetch:
  - All outputs return to reset values the next cycle.
  - After release, a fresh fetch starts at `RESET_PC` with no spurious `ack_o`.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch state encoding and word/address types for the 18-bit CPU
package cpu_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int INST_W_DEF = 18;
  typedef enum logic [1:0] {FETCH, ISSUE, DRAIN} fetch_state_t;
  typedef logic [17:0] inst_t;
  typedef logic [11:0] addr_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC + req/ack instruction fetch; ports clk/rst, stall/pc_load/target in, mem req/addr/ack/data, inst/ack/pc out
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              pc_load_i,
  input  logic [ADDR_W-1:0] pc_target_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_data_i,
  output logic [INST_W-1:0] inst_o,
  output logic              ack_o,
  output logic [ADDR_W-1:0] pc_o
);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, fetch_addr_q, fetch_addr_d, pc_out_q, pc_out_d;
  logic [INST_W-1:0] inst_q, inst_d;
  assign mem_req_o  = !rst && state_q != ISSUE;
  assign mem_addr_o = fetch_addr_q;
  assign ack_o      = !rst && state_q == ISSUE && !stall_i && !pc_load_i;
  assign inst_o     = inst_q;
  assign pc_o       = pc_out_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_load_i ? pc_target_i : pc_q;
    fetch_addr_d = fetch_addr_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    case (state_q)
      FETCH:
        if (pc_load_i) begin
          state_d      = mem_ack_i ? FETCH : DRAIN;
          fetch_addr_d = mem_ack_i ? pc_d : fetch_addr_q;
        end else if (mem_ack_i) begin
          state_d  = ISSUE;
          inst_d   = mem_data_i;
          pc_out_d = fetch_addr_q;
          pc_d     = fetch_addr_q + 1'b1;
        end
      ISSUE:
        if (pc_load_i || !stall_i) begin
          state_d      = FETCH;
          fetch_addr_d = pc_d;
        end
      DRAIN:
        if (mem_ack_i) begin
          state_d      = FETCH;
          fetch_addr_d = pc_d;
        end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      inst_q       <= '0;
      pc_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random-latency memory and transaction-level model checking fetch_unit every cycle
module tb_fetch_unit;
  localparam logic [11:0] RPC = 12'hFFF;
  logic clk = 0, rst = 1, stall_i = 0, pc_load_i = 0, mem_ack_i = 0, mem_req_o, ack_o;
  logic [11:0] pc_target_i = '0, mem_addr_o, pc_o;
  logic [17:0] mem_data_i = '0, inst_o;
  always #5 clk = ~clk;
  fetch_unit #(.ADDR_W(12), .INST_W(18), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .pc_load_i(pc_load_i), .pc_target_i(pc_target_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .inst_o(inst_o), .ack_o(ack_o), .pc_o(pc_o)
  );
  int errors = 0, checks = 0;
  int wcnt = -1, lat_lo = 0, lat_hi = 0;
  bit armed = 0, m_hold = 0, m_stale = 0;
  logic [11:0] m_pc, m_addr, m_pco;
  logic [17:0] m_inst;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit s, input bit l, input logic [11:0] t);
    bit exp_req, exp_ack;
    @(negedge clk);
    rst = r; stall_i = s; pc_load_i = l; pc_target_i = t;
    #1;
    if (!mem_req_o) begin
      wcnt = -1; mem_ack_i = 0; mem_data_i = 18'($urandom);
    end else begin
      if (wcnt < 0) wcnt = $urandom_range(lat_hi, lat_lo);
      if (wcnt == 0) begin
        mem_ack_i = 1; mem_data_i = {6'd0, mem_addr_o} ^ 18'h15555; wcnt = -1;
      end else begin
        mem_ack_i = 0; mem_data_i = 18'($urandom); wcnt--;
      end
    end
    #1;
    if (armed) begin
      exp_req = !r && !m_hold;
      exp_ack = !r && m_hold && !s && !l;
      chk("mem_req", mem_req_o, exp_req);
      chk("ack", ack_o, exp_ack);
      if (exp_req) chk("mem_addr", mem_addr_o, m_addr);
      chk("inst", inst_o, m_inst);
      chk("pc_o", pc_o, m_pco);
    end
    if (r) begin
      m_pc = RPC; m_addr = RPC; m_hold = 0; m_stale = 0; m_inst = '0; m_pco = '0; armed = 1;
    end else if (m_hold) begin
      if (l) begin m_pc = t; m_addr = t; m_hold = 0; end
      else if (!s) begin m_hold = 0; m_addr = m_pc; end
    end else if (mem_ack_i) begin
      if (m_stale || l) begin
        if (l) m_pc = t;
        m_stale = 0; m_addr = m_pc;
      end else begin
        m_inst = mem_data_i; m_pco = m_addr; m_pc = m_addr + 12'd1; m_hold = 1;
      end
    end else if (l) begin
      m_pc = t; m_stale = 1;
    end
  endtask
  task automatic wait_hold(input string name);
    int n = 0;
    while (!m_hold && n < 30) begin step(0, 0, 0, '0); n++; end
    chk(name, 32'(m_hold), 32'd1);
  endtask
  initial begin
    logic [17:0] zw_inst [3] = '{18'h15AAA, 18'h15555, 18'h15554};
    logic [11:0] zw_pc [3] = '{12'hFFF, 12'h000, 12'h001};
    int n, acks;
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    chk("reset_inst", inst_o, 0);
    chk("reset_pc_o", pc_o, 0);
    chk("reset_req", mem_req_o, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, '0);
      chk("zw_ack", ack_o, i % 2);
      if (i == 0) chk("zw_first_addr", mem_addr_o, 12'hFFF);
      if (i % 2 == 1 && i < 6) begin
        chk("zw_inst", inst_o, zw_inst[i/2]);
        chk("zw_pc", pc_o, zw_pc[i/2]);
      end
    end
    lat_lo = 3; lat_hi = 3;
    wait_hold("stall_reach");
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, '0);
      chk("stall_ack", ack_o, 0);
    end
    step(0, 0, 0, '0);
    chk("release_ack", ack_o, 1);
    step(0, 0, 0, '0);
    chk("after_release_ack", ack_o, 0);
    wait_hold("issue_reach");
    step(0, 0, 1, 12'h005);
    chk("issue_load_ack", ack_o, 0);
    step(0, 0, 0, '0);
    chk("issue_load_req", mem_req_o, 1);
    chk("issue_load_addr", mem_addr_o, 12'h005);
    step(0, 0, 1, 12'h0A0);
    chk("wait_load_addr", mem_addr_o, 12'h005);
    n = 0;
    while (!mem_ack_i && n < 10) begin
      step(0, 0, 0, '0);
      chk("drain_addr", mem_addr_o, 12'h005);
      n++;
    end
    n = 0; acks = 0;
    while (acks == 0 && n < 20) begin
      step(0, 0, 0, '0);
      if (ack_o) acks++;
      n++;
    end
    chk("jump_acked", acks, 1);
    chk("jump_pc", pc_o, 12'h0A0);
    chk("jump_inst", inst_o, 18'h155F5);
    lat_lo = 5; lat_hi = 5;
    wait_hold("rst_reach");
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(1, 0, 0, '0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_ack", ack_o, 0);
    step(1, 0, 0, '0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc_o", pc_o, 0);
    step(0, 0, 0, '0);
    chk("rst_refetch_req", mem_req_o, 1);
    chk("rst_refetch_addr", mem_addr_o, RPC);
    chk("rst_refetch_ack", ack_o, 0);
    lat_lo = 0; lat_hi = 4;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0, $urandom_range(99) < 30, $urandom_range(99) < 10, 12'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
